// File: rtl/fsm_pkg.sv
// Shared types and encodings for the multicycle RV32I main control FSM.
// Holds the state enum, opcode/immediate/mux encodings and the per-state control word decode.
package fsm_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // fetch/jal_pc mark the states whose pcupdate/irwrite are qualified outside the register.
  typedef struct packed {
    logic       mem_req;
    logic       fetch;
    logic       jal_pc;
    logic       branch;
    logic       adrsrc;
    logic       memwrite;
    logic       regwrite;
    logic       trap;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req   = 1'b1;
        c.fetch     = 1'b1;
        c.alusrca   = SRCA_PC;
        c.alusrcb   = SRCB_FOUR;
        c.aluop     = ALUOP_ADD;
        c.resultsrc = RES_ALURESULT;
      end
      DECODE: begin
        c.alusrca = SRCA_OLDPC;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALUOP_ADD;
      end
      MEMADR: begin
        c.alusrca = SRCA_RS1;
        c.alusrcb = SRCB_IMM;
      end
      MEMREAD: begin
        c.mem_req = 1'b1;
        c.adrsrc  = 1'b1;
      end
      MEMWB: begin
        c.resultsrc = RES_DATA;
        c.regwrite  = 1'b1;
      end
      MEMWRITE: begin
        c.mem_req  = 1'b1;
        c.adrsrc   = 1'b1;
        c.memwrite = 1'b1;
      end
      EXECUTER: begin
        c.alusrca = SRCA_RS1;
        c.alusrcb = SRCB_RS2;
        c.aluop   = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        c.alusrca = SRCA_RS1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALUOP_FUNCT;
      end
      JAL: begin
        c.alusrca = SRCA_OLDPC;
        c.alusrcb = SRCB_FOUR;
        c.jal_pc  = 1'b1;
      end
      ALUWB: begin
        c.resultsrc = RES_ALUOUT;
        c.regwrite  = 1'b1;
      end
      BEQ: begin
        c.alusrca = SRCA_RS1;
        c.alusrcb = SRCB_RS2;
        c.aluop   = ALUOP_SUB;
        c.branch  = 1'b1;
      end
      TRAP: begin
        c.trap = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Opcode-driven decode: immediate format select and the state that follows DECODE.
module instr_decoder
  import fsm_pkg::*;
(
  input  logic [6:0] op,
  output logic [2:0] immsrc,
  output state_t     decode_next
);

  always_comb begin
    immsrc = IMM_I;
    case (op)
      OP_SW:   immsrc = IMM_S;
      OP_BEQ:  immsrc = IMM_B;
      OP_JAL:  immsrc = IMM_J;
      default: immsrc = IMM_I;
    endcase
  end

  // Anything not in the supported RV32I subset is trapped.
  always_comb begin
    decode_next = TRAP;
    case (op)
      OP_LW, OP_SW: decode_next = MEMADR;
      OP_R:         decode_next = EXECUTER;
      OP_I:         decode_next = EXECUTEI;
      OP_BEQ:       decode_next = BEQ;
      OP_JAL:       decode_next = JAL;
      default:      decode_next = TRAP;
    endcase
  end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Moore main control FSM for the multicycle RV32I core with memory handshake,
// illegal-opcode trapping and a retired-instruction counter.
module multicycle_main_fsm
  import fsm_pkg::*;
#(
  parameter int HANDSHAKE   = 1,
  parameter int TRAP_STICKY = 1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pcupdate,
  output logic             branch,
  output logic             irwrite,
  output logic             adrsrc,
  output logic             memwrite,
  output logic             regwrite,
  output logic [1:0]       resultsrc,
  output logic [1:0]       alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [2:0]       immsrc,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);

  state_t           state_reg;
  state_t           state_next;
  state_t           decode_next;
  ctrl_t            ctrl_reg;
  logic [CNT_W-1:0] instret_reg;
  logic             ready_eff;
  logic             retire;

  assign ready_eff = (HANDSHAKE != 0) ? mem_ready : 1'b1;

  instr_decoder u_dec (
    .op          (op),
    .immsrc      (immsrc),
    .decode_next (decode_next)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:    state_next = ready_eff ? DECODE : FETCH;
      DECODE:   state_next = decode_next;
      MEMADR:   state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_next = ready_eff ? MEMWB : MEMREAD;
      MEMWB:    state_next = FETCH;
      MEMWRITE: state_next = ready_eff ? FETCH : MEMWRITE;
      EXECUTER: state_next = ALUWB;
      EXECUTEI: state_next = ALUWB;
      JAL:      state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BEQ:      state_next = FETCH;
      TRAP:     state_next = (TRAP_STICKY != 0) ? TRAP : FETCH;
      default:  state_next = FETCH;
    endcase
  end

  assign retire = (state_reg == MEMWB) || (state_reg == ALUWB) || (state_reg == BEQ) ||
                  ((state_reg == MEMWRITE) && ready_eff);

  // Control word is registered from the next state so it is valid from the first cycle of each state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= FETCH;
      ctrl_reg    <= ctrl_for(FETCH);
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= ctrl_for(state_next);
      if (retire) begin
        instret_reg <= instret_reg + CNT_W'(1);
      end
    end
  end

  // The FETCH control word doubles as the reset word, so the strobes it carries are masked by rst.
  assign mem_req   = ctrl_reg.mem_req & rst;
  assign irwrite   = ctrl_reg.fetch & ready_eff & rst;
  assign pcupdate  = ((ctrl_reg.fetch & ready_eff) | ctrl_reg.jal_pc) & rst;
  assign branch    = ctrl_reg.branch;
  assign adrsrc    = ctrl_reg.adrsrc;
  assign memwrite  = ctrl_reg.memwrite;
  assign regwrite  = ctrl_reg.regwrite;
  assign trap      = ctrl_reg.trap;
  assign resultsrc = ctrl_reg.resultsrc;
  assign alusrca   = ctrl_reg.alusrca;
  assign alusrcb   = ctrl_reg.alusrcb;
  assign aluop     = ctrl_reg.aluop;
  assign instret   = instret_reg;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for multicycle_main_fsm: default build plus a no-handshake,
// non-sticky-trap, 4-bit-counter build.
module tb_multicycle_main_fsm;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] ILL = 7'b1111111;

  // {mem_req,pcupdate,branch,irwrite,adrsrc,memwrite,regwrite, resultsrc,alusrca,alusrcb,aluop, trap}
  localparam logic [15:0] W_RESET  = {7'b0000000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [15:0] W_FETCH  = {7'b1101000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [15:0] W_FETCHW = {7'b1000000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [15:0] W_DECODE = {7'b0000000, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
  localparam logic [15:0] W_MEMADR = {7'b0000000, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
  localparam logic [15:0] W_MEMRD  = {7'b1000100, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] W_MEMWB  = {7'b0000001, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] W_MEMWR  = {7'b1000110, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] W_EXECR  = {7'b0000000, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
  localparam logic [15:0] W_EXECI  = {7'b0000000, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0};
  localparam logic [15:0] W_JAL    = {7'b0100000, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0};
  localparam logic [15:0] W_ALUWB  = {7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] W_BEQ    = {7'b0010000, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
  localparam logic [15:0] W_TRAP   = {7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [6:0] op;
  logic       mem_ready;
  logic       sel_b;
  int         n_checks = 0;
  int         n_errors = 0;

  logic        mem_req_a, pcupdate_a, branch_a, irwrite_a, adrsrc_a, memwrite_a, regwrite_a, trap_a;
  logic [1:0]  resultsrc_a, alusrca_a, alusrcb_a, aluop_a;
  logic [2:0]  immsrc_a;
  logic [31:0] instret_a;
  logic        mem_req_b, pcupdate_b, branch_b, irwrite_b, adrsrc_b, memwrite_b, regwrite_b, trap_b;
  logic [1:0]  resultsrc_b, alusrca_b, alusrcb_b, aluop_b;
  logic [2:0]  immsrc_b;
  logic [3:0]  instret_b;
  logic [15:0] ctl_a, ctl_b;

  always #5 clk = ~clk;

  multicycle_main_fsm dut_a (
    .clk(clk), .rst(rst_a), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req_a), .pcupdate(pcupdate_a), .branch(branch_a), .irwrite(irwrite_a),
    .adrsrc(adrsrc_a), .memwrite(memwrite_a), .regwrite(regwrite_a), .resultsrc(resultsrc_a),
    .alusrca(alusrca_a), .alusrcb(alusrcb_a), .aluop(aluop_a), .immsrc(immsrc_a),
    .trap(trap_a), .instret(instret_a)
  );

  multicycle_main_fsm #(.HANDSHAKE(0), .TRAP_STICKY(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst_b), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req_b), .pcupdate(pcupdate_b), .branch(branch_b), .irwrite(irwrite_b),
    .adrsrc(adrsrc_b), .memwrite(memwrite_b), .regwrite(regwrite_b), .resultsrc(resultsrc_b),
    .alusrca(alusrca_b), .alusrcb(alusrcb_b), .aluop(aluop_b), .immsrc(immsrc_b),
    .trap(trap_b), .instret(instret_b)
  );

  assign ctl_a = {mem_req_a, pcupdate_a, branch_a, irwrite_a, adrsrc_a, memwrite_a, regwrite_a,
                  resultsrc_a, alusrca_a, alusrcb_a, aluop_a, trap_a};
  assign ctl_b = {mem_req_b, pcupdate_b, branch_b, irwrite_b, adrsrc_b, memwrite_b, regwrite_b,
                  resultsrc_b, alusrca_b, alusrcb_b, aluop_b, trap_b};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check the control word, then step past the next rising edge.
  task automatic cyc(input string tag, input logic rdy, input logic [6:0] opv, input logic [15:0] exp);
    mem_ready = rdy;
    op        = opv;
    #1;
    check(tag, sel_b ? ctl_b : ctl_a, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; mem_ready = 1'b1; op = 7'd0; sel_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctl", ctl_a, W_RESET);
    check("rst_instret", instret_a, 0);
    rst_a = 1'b1;

    // lw, zero wait: 5 cycles
    cyc("lw_fetch", 1'b1, LW, W_FETCH);
    cyc("lw_decode", 1'b1, LW, W_DECODE);
    cyc("lw_memadr", 1'b1, LW, W_MEMADR);
    check("lw_instret_pre", instret_a, 0);
    cyc("lw_memread", 1'b1, LW, W_MEMRD);
    cyc("lw_memwb", 1'b1, LW, W_MEMWB);
    check("lw_instret", instret_a, 1);
    $display("txn lw   instret=%0d", instret_a);

    // sw with three wait cycles; ready ignored in DECODE
    op = SW; #1;
    check("imm_sw", immsrc_a, 3'b001);
    cyc("sw_fetch", 1'b1, SW, W_FETCH);
    cyc("sw_decode", 1'b0, SW, W_DECODE);
    cyc("sw_memadr", 1'b1, SW, W_MEMADR);
    for (int i = 0; i < 3; i++) cyc("sw_memwrite_wait", 1'b0, SW, W_MEMWR);
    check("sw_instret_wait", instret_a, 1);
    cyc("sw_memwrite_rdy", 1'b1, SW, W_MEMWR);
    check("sw_instret", instret_a, 2);
    $display("txn sw   instret=%0d", instret_a);

    // R-type with one fetch wait cycle
    op = RT; #1;
    check("imm_r", immsrc_a, 3'b000);
    cyc("r_fetch_wait", 1'b0, RT, W_FETCHW);
    cyc("r_fetch", 1'b1, RT, W_FETCH);
    cyc("r_decode", 1'b1, RT, W_DECODE);
    cyc("r_exec", 1'b1, RT, W_EXECR);
    cyc("r_aluwb", 1'b1, RT, W_ALUWB);
    check("r_instret", instret_a, 3);
    $display("txn r    instret=%0d", instret_a);

    cyc("i_fetch", 1'b1, IT, W_FETCH);
    cyc("i_decode", 1'b1, IT, W_DECODE);
    cyc("i_exec", 1'b1, IT, W_EXECI);
    cyc("i_aluwb", 1'b1, IT, W_ALUWB);
    check("i_instret", instret_a, 4);
    $display("txn i    instret=%0d", instret_a);

    op = BQ; #1;
    check("imm_beq", immsrc_a, 3'b010);
    cyc("beq_fetch", 1'b1, BQ, W_FETCH);
    cyc("beq_decode", 1'b1, BQ, W_DECODE);
    cyc("beq_beq", 1'b1, BQ, W_BEQ);
    check("beq_instret", instret_a, 5);
    $display("txn beq  instret=%0d", instret_a);

    op = JL; #1;
    check("imm_jal", immsrc_a, 3'b011);
    cyc("jal_fetch", 1'b1, JL, W_FETCH);
    cyc("jal_decode", 1'b1, JL, W_DECODE);
    cyc("jal_jal", 1'b1, JL, W_JAL);
    cyc("jal_aluwb", 1'b1, JL, W_ALUWB);
    check("jal_instret", instret_a, 6);
    $display("txn jal  instret=%0d", instret_a);

    // lw aborted by reset while stalled in MEMREAD
    cyc("ab_fetch", 1'b1, LW, W_FETCH);
    cyc("ab_decode", 1'b1, LW, W_DECODE);
    cyc("ab_memadr", 1'b1, LW, W_MEMADR);
    cyc("ab_memread", 1'b0, LW, W_MEMRD);
    check("ab_still_memread", ctl_a, W_MEMRD);
    rst_a = 1'b0; #1;
    check("ab_rst_ctl", ctl_a, W_RESET);
    check("ab_rst_instret", instret_a, 0);
    @(posedge clk); #1;
    rst_a = 1'b1;
    cyc("ab_fetch_after", 1'b1, LW, W_FETCH);
    $display("txn abort instret=%0d", instret_a);

    // illegal opcode with sticky trap
    op = ILL; #1;
    check("imm_ill", immsrc_a, 3'b000);
    cyc("ill_decode", 1'b1, ILL, W_DECODE);
    for (int i = 0; i < 10; i++) cyc("trap_sticky", 1'(i % 2), ILL, W_TRAP);
    check("trap_instret", instret_a, 0);
    $display("txn trap instret=%0d", instret_a);
    rst_a = 1'b0;

    // second build: no handshake, one-cycle trap, 4-bit counter
    sel_b = 1'b1; mem_ready = 1'b0; #1;
    check("b_rst_ctl", ctl_b, W_RESET);
    rst_b = 1'b1;
    cyc("b_fetch_noready", 1'b0, ILL, W_FETCH);
    cyc("b_decode", 1'b0, ILL, W_DECODE);
    cyc("b_trap", 1'b0, ILL, W_TRAP);
    check("b_trap_instret", instret_b, 0);
    $display("txn b trap instret=%0d", instret_b);
    for (int n = 1; n <= 17; n++) begin
      cyc("b_r_fetch", 1'b0, RT, W_FETCH);
      cyc("b_r_decode", 1'b0, RT, W_DECODE);
      cyc("b_r_exec", 1'b0, RT, W_EXECR);
      cyc("b_r_aluwb", 1'b0, RT, W_ALUWB);
      if (n == 16) check("b_instret_16", instret_b, 0);
      $display("txn b r #%0d instret=%0d", n, instret_b);
    end
    check("b_instret_wrap", instret_b, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
